game_turn_ctrl: RTL and testbench
=================================

GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_L, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port enter_L, input, 1 bit: active-low human "enter" button.
REQ-004 SHALL have port newGame_L, input, 1 bit: active-low new-game request.
REQ-005 SHALL have port hMove, input, 4 bits: human-selected number.
REQ-006 SHALL have port cMove, input, 4 bits: computer move from the strategy datapath.
REQ-007 SHALL have port cValid, input, 1 bit: cMove is valid this cycle.
REQ-008 SHALL have port cReq, output, 1 bit: requests a computer move from the strategy datapath.
REQ-009 SHALL have ports hTaken and cTaken, output, 9 bits each: bit n-1 set means number n is owned by the human or computer respectively.
REQ-010 SHALL have ports hTurn, illegal, humanWin, compWin and draw, output, 1 bit each: status flags.

Function
REQ-011 Legal move SHALL mean value 1..9 with the matching bit clear in both hTaken and cTaken.
REQ-012 Enter press SHALL be detected on the edge only: registered enter_L was 1 and current enter_L is 0; holding enter_L low yields one press.
REQ-013 FSM states SHALL be NEW, C_REQ, EVAL_C, H_WAIT, EVAL_H, H_WIN, C_WIN, DRAW.
REQ-014 H_WAIT SHALL assert hTurn; a legal press sets the hTaken bit, clears illegal and enters EVAL_H on the next cycle.
REQ-015 H_WAIT SHALL set illegal on an illegal press and stay in H_WAIT; illegal remains set until the next legal press or NEW.
REQ-016 EVAL_H SHALL go to H_WIN if win_check(hTaken) is true, else to DRAW if hTaken|cTaken == 9'h1FF, else to C_REQ.
REQ-017 C_REQ SHALL hold cReq=1 until cValid; a legal cMove sets the cTaken bit and enters EVAL_C; an illegal cMove is ignored and cReq stays high.
REQ-018 EVAL_C SHALL go to C_WIN if win_check(cTaken) is true, else to DRAW if the board is full, else to H_WAIT.
REQ-019 Latency SHALL be: press sampled in cycle n gives hTaken updated at n+1 and cReq high at n+2; cValid in cycle m gives cTaken at m+1 and hTurn at m+2.
REQ-020 In H_WIN, C_WIN and DRAW the block SHALL assert humanWin, compWin or draw respectively, hold the bitmaps, and ignore enter and cValid.
REQ-021 newGame_L=0 in any state SHALL force NEW, clear both bitmaps and all flags, and hold NEW while low.
REQ-022 On newGame_L release the block SHALL leave NEW for the start state (REQ-027).
REQ-023 newGame_L SHALL take priority over a simultaneous press or cValid.
REQ-024 Enter presses outside H_WAIT SHALL be ignored and SHALL NOT be queued.

Reset
REQ-025 While reset_L=0 at a rising edge the block SHALL enter NEW with hTaken=cTaken=0, cReq=0 and all flags 0; the enter edge register SHALL be set to 1.
REQ-026 Reset SHALL override newGame_L, and reset mid-game SHALL discard all board state.

Configuration
REQ-027 Macro GAME_COMP_FIRST_EN SHALL select the first player: defined, NEW exits to C_REQ so the computer moves first; undefined, NEW exits to H_WAIT.

Structure
REQ-028 Package game_pkg SHALL hold the state enum, typedef move_t (4 bits), NUM_CELLS=9 and WIN_SUM=15.
REQ-029 Sub-module win_check SHALL be combinational: 9-bit set in, true if any three distinct owned numbers sum to 15 (8 triples).

Verification
REQ-030 With GAME_COMP_FIRST_EN, release reset and return cMove=5 -> cTaken=9'h010 and hTurn=1 two cycles after cValid.
REQ-031 After C owns 5, press with hMove=5, then hMove=0, then hMove=10 -> illegal=1 and hTaken unchanged each time; a later press with hMove=6 clears illegal.
REQ-032 Macro on, sequence C5,H6,C1,H9,C3,H2,C7 -> compWin=1 one cycle after cTaken=9'h055 and humanWin=0.
REQ-033 Macro off, sequence H1,C6,H2,C7,H3,C8,H4,C9,H5 -> draw=1 with hTaken=9'h01F and cTaken=9'h1E0.
REQ-034 Hold enter_L low 5 cycles in H_WAIT -> exactly one hTaken bit set; a press during C_REQ -> no change.
REQ-035 Mid-game, drive newGame_L=0 for 3 cycles together with cValid -> bitmaps and flags 0 while low; on release the game restarts per macro.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state enum, move type and board constants for the sum-to-15 game.
package game_pkg;
  localparam int NUM_CELLS = 9;
  localparam int WIN_SUM = 15;
  typedef logic [3:0] move_t;
  typedef enum logic [2:0] {NEW, C_REQ, EVAL_C, H_WAIT, EVAL_H, H_WIN, C_WIN, DRAW} state_t;
  function automatic logic [NUM_CELLS-1:0] cell_mask(input move_t m);
    return (m >= 4'd1 && m <= 4'd9) ? NUM_CELLS'(1) << (m - 4'd1) : '0;
  endfunction
endpackage

// File: rtl/game_turn_ctrl_win_check.sv
// win_check: true when any three distinct owned numbers sum to WIN_SUM.
module win_check
  import game_pkg::*;
(
  input  logic [NUM_CELLS-1:0] cells,
  output logic                 win
);
  always_comb begin
    win = 1'b0;
    for (int i = 1; i <= NUM_CELLS; i++)
      for (int j = i + 1; j <= NUM_CELLS; j++)
        for (int k = j + 1; k <= NUM_CELLS; k++)
          if (i + j + k == WIN_SUM && cells[i-1] && cells[j-1] && cells[k-1]) win = 1'b1;
  end
endmodule

// File: rtl/game_turn_ctrl.sv
// game_turn_ctrl: turn sequencing for the sum-to-15 game.
// Define GAME_COMP_FIRST_EN to let the computer move first after NEW.
module game_turn_ctrl
  import game_pkg::*;
(
  input  logic       clock,
  input  logic       reset_L,
  input  logic       enter_L,
  input  logic       newGame_L,
  input  logic [3:0] hMove,
  input  logic [3:0] cMove,
  input  logic       cValid,
  output logic       cReq,
  output logic [8:0] hTaken,
  output logic [8:0] cTaken,
  output logic       hTurn,
  output logic       illegal,
  output logic       humanWin,
  output logic       compWin,
  output logic       draw
);
`ifdef GAME_COMP_FIRST_EN
  localparam state_t FIRST = C_REQ;
`else
  localparam state_t FIRST = H_WAIT;
`endif
  state_t state, next;
  logic enter_q, press, h_ok, c_ok, h_win, c_win, full, ill_nx;
  logic [8:0] h_mask, c_mask, h_nx, c_nx;
  assign press  = enter_q & ~enter_L;
  assign h_mask = cell_mask(hMove);
  assign c_mask = cell_mask(cMove);
  assign h_ok   = h_mask != '0 && (h_mask & (hTaken | cTaken)) == '0;
  assign c_ok   = c_mask != '0 && (c_mask & (hTaken | cTaken)) == '0;
  assign full   = &(hTaken | cTaken);
  assign hTurn    = state == H_WAIT;
  assign cReq     = state == C_REQ;
  assign humanWin = state == H_WIN;
  assign compWin  = state == C_WIN;
  assign draw     = state == DRAW;
  win_check u_hwin (.cells(hTaken), .win(h_win));
  win_check u_cwin (.cells(cTaken), .win(c_win));
  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state   <= NEW;
      hTaken  <= '0;
      cTaken  <= '0;
      illegal <= 1'b0;
      enter_q <= 1'b1;
    end else begin
      state   <= next;
      hTaken  <= h_nx;
      cTaken  <= c_nx;
      illegal <= ill_nx;
      enter_q <= enter_L;
    end
  end
  always_comb begin
    next   = state;
    h_nx   = hTaken;
    c_nx   = cTaken;
    ill_nx = illegal;
    if (!newGame_L) begin
      next   = NEW;
      h_nx   = '0;
      c_nx   = '0;
      ill_nx = 1'b0;
    end else begin
      case (state)
        NEW:    next = FIRST;
        H_WAIT: if (press) begin
          ill_nx = !h_ok;
          if (h_ok) begin
            h_nx = hTaken | h_mask;
            next = EVAL_H;
          end
        end
        EVAL_H: next = h_win ? H_WIN : full ? DRAW : C_REQ;
        C_REQ:  if (cValid && c_ok) begin
          c_nx = cTaken | c_mask;
          next = EVAL_C;
        end
        EVAL_C: next = c_win ? C_WIN : full ? DRAW : H_WAIT;
        default: next = state;
      endcase
    end
  end
endmodule

// File: tb/tb_game_turn_ctrl.sv
// tb_game_turn_ctrl: table-driven scoreboard bench for game_turn_ctrl.
module tb_game_turn_ctrl;
  logic clock = 1'b0, reset_L = 1'b0, enter_L = 1'b1, newGame_L = 1'b1, cValid = 1'b0;
  logic [3:0] hMove = '0, cMove = '0;
  logic cReq, hTurn, illegal, humanWin, compWin, draw;
  logic [8:0] hTaken, cTaken;
  logic [4:0] st;
  int checks = 0, errors = 0;
`ifdef GAME_COMP_FIRST_EN
  localparam logic [4:0] START = 5'b01000;
  localparam logic [8:0] C0 = 9'h010;
`else
  localparam logic [4:0] START = 5'b10000;
  localparam logic [8:0] C0 = 9'h000;
`endif
  typedef struct {
    int         kind;
    logic [3:0] mv;
    logic [8:0] h;
    logic [8:0] c;
    logic       ill;
    logic [4:0] st;
  } row_t;
  row_t tbl[$];
  row_t sb[$];
  assign st = {hTurn, cReq, humanWin, compWin, draw};
  always #5 clock = ~clock;
  game_turn_ctrl dut (
    .clock(clock), .reset_L(reset_L), .enter_L(enter_L), .newGame_L(newGame_L),
    .hMove(hMove), .cMove(cMove), .cValid(cValid), .cReq(cReq),
    .hTaken(hTaken), .cTaken(cTaken), .hTurn(hTurn), .illegal(illegal),
    .humanWin(humanWin), .compWin(compWin), .draw(draw)
  );
  function automatic row_t r(int k, logic [3:0] m, logic [8:0] h, logic [8:0] c, logic ill, logic [4:0] s);
    row_t x;
    x.kind = k; x.mv = m; x.h = h; x.c = c; x.ill = ill; x.st = s;
    return x;
  endfunction
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  // kind: 0 human press, 1 computer move, 2 newGame pulse, 3 press+cValid together
  task automatic run(input row_t x);
    row_t e;
    sb.push_back(x);
    case (x.kind)
      0: begin hMove = x.mv; enter_L = 1'b0; end
      1: begin cMove = x.mv; cValid = 1'b1; end
      2: begin newGame_L = 1'b0; cValid = 1'b1; cMove = x.mv; hMove = x.mv; enter_L = 1'b0; end
      default: begin hMove = x.mv; cMove = x.mv; enter_L = 1'b0; cValid = 1'b1; end
    endcase
    tick;
    e = sb.pop_front();
    if (x.kind == 2) begin
      for (int i = 0; i < 3; i++) begin
        chk("ng_hTaken", hTaken, e.h);
        chk("ng_cTaken", cTaken, e.c);
        chk("ng_flags", {illegal, st}, 6'd0);
        if (i < 2) tick;
      end
      newGame_L = 1'b1; cValid = 1'b0; enter_L = 1'b1;
      tick;
      chk("ng_release", st, e.st);
    end else begin
      chk("hTaken", hTaken, e.h);
      chk("cTaken", cTaken, e.c);
      chk("illegal", illegal, e.ill);
      enter_L = 1'b1; cValid = 1'b0;
      tick;
      chk("status", st, e.st);
    end
  endtask
  initial begin
    tbl.push_back(r(2, 3, 9'h000, 9'h000, 0, START));
`ifdef GAME_COMP_FIRST_EN
    tbl.push_back(r(1, 5,  9'h000, 9'h010, 0, 5'b10000));
    tbl.push_back(r(0, 5,  9'h000, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 0,  9'h000, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 10, 9'h000, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 6,  9'h020, 9'h010, 0, 5'b01000));
    tbl.push_back(r(1, 1,  9'h020, 9'h011, 0, 5'b10000));
    tbl.push_back(r(0, 9,  9'h120, 9'h011, 0, 5'b01000));
    tbl.push_back(r(1, 3,  9'h120, 9'h015, 0, 5'b10000));
    tbl.push_back(r(0, 2,  9'h122, 9'h015, 0, 5'b01000));
    tbl.push_back(r(1, 7,  9'h122, 9'h055, 0, 5'b00010));
    tbl.push_back(r(3, 8,  9'h122, 9'h055, 0, 5'b00010));
    tbl.push_back(r(2, 3,  9'h000, 9'h000, 0, START));
    tbl.push_back(r(1, 9,  9'h000, 9'h100, 0, 5'b10000));
`else
    tbl.push_back(r(0, 1, 9'h001, 9'h000, 0, 5'b01000));
    tbl.push_back(r(1, 6, 9'h001, 9'h020, 0, 5'b10000));
    tbl.push_back(r(0, 2, 9'h003, 9'h020, 0, 5'b01000));
    tbl.push_back(r(1, 7, 9'h003, 9'h060, 0, 5'b10000));
    tbl.push_back(r(0, 3, 9'h007, 9'h060, 0, 5'b01000));
    tbl.push_back(r(1, 8, 9'h007, 9'h0E0, 0, 5'b10000));
    tbl.push_back(r(0, 4, 9'h00F, 9'h0E0, 0, 5'b01000));
    tbl.push_back(r(1, 9, 9'h00F, 9'h1E0, 0, 5'b10000));
    tbl.push_back(r(0, 5, 9'h01F, 9'h1E0, 0, 5'b00001));
    tbl.push_back(r(3, 6, 9'h01F, 9'h1E0, 0, 5'b00001));
    tbl.push_back(r(2, 3, 9'h000, 9'h000, 0, START));
    tbl.push_back(r(0, 1,  9'h001, 9'h000, 0, 5'b01000));
    tbl.push_back(r(1, 5,  9'h001, 9'h010, 0, 5'b10000));
    tbl.push_back(r(0, 5,  9'h001, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 0,  9'h001, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 10, 9'h001, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 1,  9'h001, 9'h010, 1, 5'b10000));
    tbl.push_back(r(0, 6,  9'h021, 9'h010, 0, 5'b01000));
    tbl.push_back(r(1, 6,  9'h021, 9'h010, 0, 5'b01000));
    tbl.push_back(r(1, 0,  9'h021, 9'h010, 0, 5'b01000));
    tbl.push_back(r(1, 9,  9'h021, 9'h110, 0, 5'b10000));
    tbl.push_back(r(0, 2,  9'h023, 9'h110, 0, 5'b01000));
    tbl.push_back(r(1, 3,  9'h023, 9'h114, 0, 5'b10000));
    tbl.push_back(r(0, 4,  9'h02B, 9'h114, 0, 5'b01000));
    tbl.push_back(r(1, 7,  9'h02B, 9'h154, 0, 5'b00010));
    tbl.push_back(r(3, 8,  9'h02B, 9'h154, 0, 5'b00010));
    tbl.push_back(r(2, 3,  9'h000, 9'h000, 0, START));
    tbl.push_back(r(0, 4,  9'h008, 9'h000, 0, 5'b01000));
    tbl.push_back(r(1, 1,  9'h008, 9'h001, 0, 5'b10000));
    tbl.push_back(r(0, 5,  9'h018, 9'h001, 0, 5'b01000));
    tbl.push_back(r(1, 2,  9'h018, 9'h003, 0, 5'b10000));
    tbl.push_back(r(0, 6,  9'h038, 9'h003, 0, 5'b00100));
    tbl.push_back(r(3, 9,  9'h038, 9'h003, 0, 5'b00100));
    tbl.push_back(r(2, 3,  9'h000, 9'h000, 0, START));
    tbl.push_back(r(0, 9,  9'h100, 9'h000, 0, 5'b01000));
`endif
    tick;
    tick;
    chk("rst_hTaken", hTaken, 9'h000);
    chk("rst_cTaken", cTaken, 9'h000);
    chk("rst_flags", {illegal, st}, 6'd0);
    reset_L = 1'b1;
    tick;
    chk("start_state", st, START);
`ifdef GAME_COMP_FIRST_EN
    run(r(1, 5, 9'h000, 9'h010, 0, 5'b10000));
`endif
    hMove = 4'd7;
    enter_L = 1'b0;
    repeat (5) tick;
    chk("hold_hTaken", hTaken, 9'h040);
    chk("hold_cTaken", cTaken, C0);
    chk("hold_status", st, 5'b01000);
    enter_L = 1'b1;
    tick;
    hMove = 4'd8;
    enter_L = 1'b0;
    tick;
    chk("creq_press_hTaken", hTaken, 9'h040);
    enter_L = 1'b1;
    tick;
    chk("creq_press_status", st, 5'b01000);
    foreach (tbl[i]) run(tbl[i]);
    reset_L = 1'b0;
    tick;
    chk("midrst_hTaken", hTaken, 9'h000);
    chk("midrst_cTaken", cTaken, 9'h000);
    chk("midrst_flags", {illegal, st}, 6'd0);
    reset_L = 1'b1;
    tick;
    chk("midrst_start", st, START);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
